// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: two line buffers feed a 3x3 window, one result per
// accepted pixel, valid/ready on both sides, four output modes and a button-set threshold.
module sobel_stream_filter #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int GRAY_W   = 5,
    parameter int PX_W     = 15,
    parameter int THR_INIT = 40,
    parameter int THR_STEP = 4
) (
    input  logic              sobel_clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              threshold_up,
    input  logic              threshold_down,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PX_W-1:0]   input_px_gray,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PX_W-1:0]   output_px_sobel,
    output logic [GRAY_W+3:0] threshold,
    output logic              frame_done
);

    localparam int THR_W = GRAY_W + 4;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    localparam logic [CW-1:0]    COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [THR_W-1:0] PX_MAX     = THR_W'((1 << GRAY_W) - 1);
    localparam logic [THR_W-1:0] THR_MAX    = '1;
    localparam logic [THR_W-1:0] THR_STEP_V = THR_W'(THR_STEP);
    localparam logic [THR_W-1:0] THR_RST    = THR_W'(THR_INIT);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
    logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;

    logic [GRAY_W-1:0] win1_q [3];
    logic [GRAY_W-1:0] win1_d [3];
    logic [GRAY_W-1:0] win2_q [3];
    logic [GRAY_W-1:0] win2_d [3];

    logic [GRAY_W-1:0] line0_mem [IMG_W];
    logic [GRAY_W-1:0] line1_mem [IMG_W];

    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [GRAY_W-1:0] out_px_q, out_px_d;

    logic [THR_W-1:0]  thr_q, thr_d;
    logic              up_prev_q, up_prev_d;
    logic              down_prev_q, down_prev_d;

    logic              accept, slot_free, produce;
    logic              in_last, out_is_last, border;
    logic [GRAY_W-1:0] px_in, lb_top, lb_mid, result;
    logic              unused_upper;

    logic signed [THR_W-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
    logic signed [THR_W-1:0] gx, gy;
    logic [THR_W-1:0]        abs_gx, abs_gy, mag;
    logic [THR_W:0]          thr_sum;

    function automatic logic signed [THR_W-1:0] ext(input logic [GRAY_W-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    function automatic logic [THR_W-1:0] abs_val(input logic signed [THR_W-1:0] v);
        return v[THR_W-1] ? -v : v;
    endfunction

    function automatic logic [GRAY_W-1:0] sat(input logic [THR_W-1:0] v);
        return (v > PX_MAX) ? {GRAY_W{1'b1}} : v[GRAY_W-1:0];
    endfunction

    assign px_in        = input_px_gray[GRAY_W-1:0];
    assign unused_upper = ^input_px_gray[PX_W-1:GRAY_W];
    assign lb_top       = line1_mem[in_col_q];
    assign lb_mid       = line0_mem[in_col_q];

    assign slot_free   = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    assign in_last     = (in_col_q == COL_LAST) && (in_row_q == ROW_LAST);
    assign out_is_last = (out_col_q == COL_LAST) && (out_row_q == ROW_LAST);
    assign border      = (out_col_q == '0) || (out_col_q == COL_LAST) ||
                         (out_row_q == '0) || (out_row_q == ROW_LAST);

    // Window columns: win2 is two pixels back, win1 one back, the third is the incoming column.
    assign p00 = ext(win2_q[0]);
    assign p10 = ext(win2_q[1]);
    assign p20 = ext(win2_q[2]);
    assign p01 = ext(win1_q[0]);
    assign p21 = ext(win1_q[2]);
    assign p02 = ext(lb_top);
    assign p12 = ext(lb_mid);
    assign p22 = ext(px_in);

    assign gx     = (p02 + p12 + p12 + p22) - (p00 + p10 + p10 + p20);
    assign gy     = (p20 + p21 + p21 + p22) - (p00 + p01 + p01 + p02);
    assign abs_gx = abs_val(gx);
    assign abs_gy = abs_val(gy);
    assign mag    = abs_gx + abs_gy;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sobel_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (accept && in_row_q == RW'(1) && in_col_q == '0) state_d = S_RUN;
            S_RUN:   if (accept && in_last) state_d = S_FLUSH;
            S_FLUSH: if (out_valid_q && out_ready && out_last_q) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_FILL:  in_ready = 1'b1;
            S_RUN:   in_ready = slot_free;
            S_FLUSH: frame_done = out_valid_q && out_ready && out_last_q;
            default: in_ready = 1'b0;
        endcase
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        out_valid_d = out_valid_q;
        out_px_d    = out_px_q;
        out_last_d  = out_last_q;
        result      = '0;

        produce = (state_q == S_RUN && accept) ||
                  (state_q == S_FLUSH && slot_free && !(out_valid_q && out_last_q));

        if (accept) begin
            win2_d = win1_q;
            win1_d = '{lb_top, lb_mid, px_in};
            if (in_col_q == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
            end else begin
                in_col_d = in_col_q + 1'b1;
            end
        end

        // Flush centres are all on the border, so only RUN computes a gradient.
        if (state_q == S_RUN && !border) begin
            case (mode)
                2'd0:    result = sat(mag);
                2'd1:    result = (mag > thr_q) ? {GRAY_W{1'b1}} : '0;
                2'd2:    result = sat(abs_gx);
                default: result = sat(abs_gy);
            endcase
        end

        if (produce) begin
            out_valid_d = 1'b1;
            out_px_d    = result;
            out_last_d  = out_is_last;
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---------------- Threshold buttons ----------------
    always_comb begin
        up_prev_d   = threshold_up;
        down_prev_d = threshold_down;
        thr_d       = thr_q;
        thr_sum     = {1'b0, thr_q} + {1'b0, THR_STEP_V};
        if (threshold_up && !up_prev_q && !(threshold_down && !down_prev_q)) begin
            thr_d = thr_sum[THR_W] ? THR_MAX : thr_sum[THR_W-1:0];
        end else if (threshold_down && !down_prev_q && !(threshold_up && !up_prev_q)) begin
            thr_d = (thr_q < THR_STEP_V) ? '0 : thr_q - THR_STEP_V;
        end
    end

    always_ff @(posedge sobel_clk or posedge reset) begin
        if (reset) begin
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            win1_q      <= '{default: '0};
            win2_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            out_px_q    <= '0;
            out_last_q  <= 1'b0;
            thr_q       <= THR_RST;
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
        end else begin
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            win1_q      <= win1_d;
            win2_q      <= win2_d;
            out_valid_q <= out_valid_d;
            out_px_q    <= out_px_d;
            out_last_q  <= out_last_d;
            thr_q       <= thr_d;
            up_prev_q   <= up_prev_d;
            down_prev_q <= down_prev_d;
        end
    end

    // NOTE: line buffers carry no reset; rows 0/1 only feed border centres, which output 0.
    always_ff @(posedge sobel_clk) begin
        if (accept) begin
            line0_mem[in_col_q] <= px_in;
            line1_mem[in_col_q] <= lb_mid;
        end
    end

    assign out_valid       = out_valid_q;
    assign output_px_sobel = {3{out_px_q}};
    assign threshold       = thr_q;

endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
- Parametrised successor to the fixed 320x240 Sobel control block.
- Streaming 3x3 Sobel edge filter for grey frames of any size, with valid/ready handshakes on input and output.
- Holds two line buffers and has four output modes: magnitude, binary threshold, |Gx| and |Gy|.
- The threshold is set with up/down buttons.
- Sits between the greyscale converter and the output frame-buffer writer. Emits exactly IMG_W*IMG_H pixels per frame.

Parameters:
- IMG_W, 320, pixels per line (>=4)
- IMG_H, 240, lines per frame (>=3)
- GRAY_W, 5, bits per grey sample
- PX_W, 15, bus pixel width; must equal 3*GRAY_W
- THR_INIT, 40, threshold after reset
- THR_STEP, 4, threshold increment/decrement per button press

Ports:
- sobel_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  0=magnitude, 1=binary threshold, 2=|Gx|, 3=|Gy|
- threshold_up  in  1  level button, rising-edge detected
- threshold_down  in  1  level button, rising-edge detected
- in_valid  in  1  input pixel valid
- in_ready  out  1  input accepted when in_valid&&in_ready
- input_px_gray  in  PX_W  grey sample in bits [GRAY_W-1:0]; upper bits ignored
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- output_px_sobel  out  PX_W  result replicated in all three GRAY_W fields
- threshold  out  GRAY_W+4  current threshold
- frame_done  out  1  one-cycle pulse when the last output of a frame is accepted

Behaviour:
- Reset values:
  - state=FILL; all counters 0.
  - out_valid=0, output_px_sobel=0, frame_done=0, threshold=THR_INIT.
  - Line-buffer contents are don't-care.
- FSM:
  - FILL: in_ready=1, no output. After IMG_W+1 accepted pixels, go to RUN.
  - RUN: in_ready = !out_valid || out_ready. Each accepted pixel k produces output for centre index k-(IMG_W+1), registered; out_valid rises the cycle after acceptance. When the last frame pixel is accepted, go to FLUSH.
  - FLUSH: in_ready=0. Emits IMG_W+1 outputs, all value 0 (bottom line and last pixel of line IMG_H-2 are border), one per cycle under out_ready. After the last is accepted: frame_done pulses, go to FILL.
- Output register is held stable while out_valid && !out_ready. Full throughput is 1 pixel/clk.
- Window: two line buffers of IMG_W words each plus 3x3 shift window. Border centres (row 0, row IMG_H-1, col 0, col IMG_W-1) output 0 in every mode; no wrap between lines.
- Arithmetic:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Signed, GRAY_W+4 bits; mag = |Gx|+|Gy| in GRAY_W+4 bits, no overflow.
  - Mode 0/2/3: value saturated to 2^GRAY_W-1.
  - Mode 1: mag > threshold gives 2^GRAY_W-1, else 0.
- mode is sampled per output pixel. A change mid-frame takes effect on the next produced pixel.
- Threshold:
  - Rising edge of threshold_up adds THR_STEP, saturating at 2^(GRAY_W+4)-1.
  - Rising edge of threshold_down subtracts, saturating at 0.
  - Both edges in the same cycle: no change.
- Counters: input col/row and output col/row wrap at IMG_W-1/IMG_H-1.
- Reset asserted mid-frame aborts immediately to reset values; the next accepted pixel is treated as pixel (0,0).

Test Plan:
- IMG_W=8, IMG_H=6, flat image value 17, mode 0, out_ready=1 -> 48 outputs all 0; first out_valid 10 cycles after first accept; frame_done pulses once.
- Vertical edge (cols 0-3=0, cols 4-7=31), mode 2 -> interior cols 3,4 output 0x7FFF (31 saturated); other cols 0; border 0.
- Same image, mode 1: THR_INIT=40 -> interior cols 3,4 = 0x7FFF (mag 124). Press up 22 times (threshold=128) -> those pixels become 0.
- threshold_down pressed 15 times from 40 -> threshold 0, stays 0. threshold_up held high 100 cycles -> +4 only once.
- Random out_ready (50%) with a ramp image -> output sequence identical to the out_ready=1 run; output stable while stalled; no input loss.
- Reset asserted at pixel 20 of frame 1, then a full frame is sent -> exactly 48 outputs matching the golden model; no stale data emitted.
